// File: rtl/neuron_mac_lanes.sv
// Multi-lane fixed-point MAC neuron (bias, rescale, saturate, activation) with cfg-bus weight load.
// out_valid rises 5 edges after the final beat is accepted; in_ready low outside IDLE/ACCUM, result held until out_ready.
module neuron_mac_lanes #(
  parameter int LAYER_NO   = 1,
  parameter int NEURON_NO  = 0,
  parameter int NUM_WEIGHT = 128,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int LANES      = 2,
  parameter int ACT_MODE   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 cfg_layer_num,
  input  logic [31:0]                 cfg_neuron_num,
  input  logic                        weight_valid,
  input  logic [DATA_WIDTH-1:0]       weight_value,
  input  logic                        bias_valid,
  input  logic [DATA_WIDTH-1:0]       bias_value,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        sat_flag,
  output logic                        weights_loaded
);

  localparam int DW    = DATA_WIDTH;
  localparam int ROWS  = NUM_WEIGHT / LANES;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int ACC_W = 2*DW + $clog2(NUM_WEIGHT);

  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DRAIN, S_BIAS, S_OUT} state_t;
  state_t state, state_nxt;

  logic                    cfg_match, wr_en, bias_en, accept, last_beat, drained;
  logic [BW-1:0]           w_bank;
  logic [RW-1:0]           w_row;
  logic [RW-1:0]           beat_cnt;
  logic signed [DW-1:0]    wmem [LANES][ROWS];

  logic                    a_vld, b_vld, c_vld;
  logic [RW-1:0]           a_row;
  logic signed [DW-1:0]    a_x    [LANES];
  logic signed [DW-1:0]    b_x    [LANES];
  logic signed [DW-1:0]    b_w    [LANES];
  logic signed [2*DW-1:0]  c_prod [LANES];

  logic signed [DW-1:0]    bias_q;
  logic signed [ACC_W-1:0] acc, tree_sum, bias_ext, acc_biased, res;
  logic [DW-1:0]           res_clamp, res_act;
  logic                    res_sat;

  assign cfg_match = (cfg_layer_num == 32'(LAYER_NO)) && (cfg_neuron_num == 32'(NEURON_NO));
  assign wr_en     = weight_valid && cfg_match && (state == S_IDLE);
  assign bias_en   = bias_valid && cfg_match && (state == S_IDLE);
  assign in_ready  = weights_loaded && ((state == S_IDLE) || (state == S_ACCUM));
  assign accept    = in_valid && in_ready;
  assign last_beat = (beat_cnt == RW'(ROWS-1));
  assign drained   = !a_vld && !b_vld && !c_vld;
  assign out_valid = (state == S_OUT);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_ACCUM: if (accept) state_nxt = last_beat ? S_DRAIN : S_ACCUM;
      S_DRAIN:         if (drained) state_nxt = S_BIAS;
      S_BIAS:          state_nxt = S_OUT;
      S_OUT:           if (out_ready) state_nxt = S_IDLE;
      default:         state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      w_bank         <= '0;
      w_row          <= '0;
      weights_loaded <= 1'b0;
      beat_cnt       <= '0;
      a_vld          <= 1'b0;
      b_vld          <= 1'b0;
      c_vld          <= 1'b0;
    end else begin
      state <= state_nxt;
      a_vld <= accept;
      b_vld <= a_vld;
      c_vld <= b_vld;
      if (accept) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      // address a lives in bank a%LANES, row a/LANES; the last write wraps and marks the set complete
      if (wr_en) begin
        if (w_bank == BW'(LANES-1)) begin
          w_bank <= '0;
          if (w_row == RW'(ROWS-1)) begin
            w_row          <= '0;
            weights_loaded <= 1'b1;
          end else begin
            w_row <= w_row + 1'b1;
          end
        end else begin
          w_bank <= w_bank + 1'b1;
        end
      end
    end
  end

  // Weight RAM is deliberately left out of reset so a reset does not need a full reload cycle to clear it
  always_ff @(posedge clk) begin
    if (wr_en) wmem[w_bank][w_row] <= weight_value;
    for (int k = 0; k < LANES; k++) b_w[k] <= wmem[k][a_row];
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_row <= beat_cnt;
      for (int k = 0; k < LANES; k++) a_x[k] <= in_data[k*DW +: DW];
    end
    for (int k = 0; k < LANES; k++) begin
      b_x[k]    <= a_x[k];
      c_prod[k] <= b_w[k] * b_x[k];
    end
  end

  always_comb begin
    tree_sum = '0;
    for (int k = 0; k < LANES; k++) tree_sum = tree_sum + ACC_W'(c_prod[k]);
  end

  assign bias_ext   = ACC_W'(bias_q);
  assign acc_biased = acc + (bias_ext <<< FRAC_WIDTH);
  assign res        = acc_biased >>> FRAC_WIDTH;

  always_comb begin
    res_sat   = 1'b0;
    res_clamp = res[DW-1:0];
    if (res > MAXV) begin
      res_clamp = MAXV[DW-1:0];
      res_sat   = 1'b1;
    end else if (res < MINV) begin
      res_clamp = MINV[DW-1:0];
      res_sat   = 1'b1;
    end
    res_act = res_clamp;
    if (ACT_MODE == 1 && res_clamp[DW-1]) res_act = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      bias_q   <= '0;
      out_data <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (bias_en) bias_q <= bias_value;
      if (state == S_BIAS) begin
        acc      <= acc_biased;
        out_data <= res_act;
        sat_flag <= res_sat;
      end else if (state == S_OUT && out_ready) begin
        acc <= '0;
      end else if (c_vld) begin
        acc <= acc + tree_sum;
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac_lanes.sv
// Directed bench for neuron_mac_lanes with ReLU and linear instances driven in lockstep.
// Stimulus queues hand-computed results; a negedge monitor checks them on each output handshake.
module tb_neuron_mac_lanes;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_layer_num, cfg_neuron_num;
  logic        weight_valid, bias_valid, in_valid, out_ready;
  logic [15:0] weight_value, bias_value;
  logic [31:0] in_data;

  logic        in_ready_r, out_valid_r, sat_r, wl_r;
  logic        in_ready_l, out_valid_l, sat_l, wl_l;
  logic [15:0] out_data_r, out_data_l;

  neuron_mac_lanes #(.LAYER_NO(1), .NEURON_NO(0), .NUM_WEIGHT(4), .DATA_WIDTH(16),
                     .FRAC_WIDTH(8), .LANES(2), .ACT_MODE(1)) dut (
    .clk(clk), .rst(rst), .cfg_layer_num(cfg_layer_num), .cfg_neuron_num(cfg_neuron_num),
    .weight_valid(weight_valid), .weight_value(weight_value),
    .bias_valid(bias_valid), .bias_value(bias_value),
    .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
    .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r),
    .sat_flag(sat_r), .weights_loaded(wl_r));

  neuron_mac_lanes #(.LAYER_NO(1), .NEURON_NO(0), .NUM_WEIGHT(4), .DATA_WIDTH(16),
                     .FRAC_WIDTH(8), .LANES(2), .ACT_MODE(0)) dut_lin (
    .clk(clk), .rst(rst), .cfg_layer_num(cfg_layer_num), .cfg_neuron_num(cfg_neuron_num),
    .weight_valid(weight_valid), .weight_value(weight_value),
    .bias_valid(bias_valid), .bias_value(bias_value),
    .in_valid(in_valid), .in_ready(in_ready_l), .in_data(in_data),
    .out_valid(out_valid_l), .out_ready(out_ready), .out_data(out_data_l),
    .sat_flag(sat_l), .weights_loaded(wl_l));

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] relu;
    logic [15:0] lin;
    logic        sat;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic note_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout, expected event within bound", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: latency on first valid cycle, stability while stalled, values on handshake
  logic        hold_vld = 1'b0;
  logic [15:0] hold_dat;
  logic        hold_sat;

  always @(negedge clk) begin
    if (rst) begin
      hold_vld = 1'b0;
    end else if (out_valid_r) begin
      check("lin_valid_align", out_valid_l, 1'b1);
      check("in_ready_during_out", in_ready_r, 1'b0);
      if (hold_vld) begin
        check("hold_out_data", out_data_r, hold_dat);
        check("hold_sat_flag", sat_r, hold_sat);
      end else if (sb.size() != 0) begin
        check($sformatf("latency_t%0d", sb[0].id), cyc, sb[0].cyc);
      end
      if (sb.size() == 0) begin
        note_fail("unexpected_output");
      end else if (out_ready) begin
        check($sformatf("out_relu_t%0d", sb[0].id), out_data_r, sb[0].relu);
        check($sformatf("out_lin_t%0d", sb[0].id), out_data_l, sb[0].lin);
        check($sformatf("sat_relu_t%0d", sb[0].id), sat_r, sb[0].sat);
        check($sformatf("sat_lin_t%0d", sb[0].id), sat_l, sb[0].sat);
        void'(sb.pop_front());
      end
      hold_vld = !out_ready;
      hold_dat = out_data_r;
      hold_sat = sat_r;
    end else begin
      if (hold_vld) note_fail("valid_dropped_without_handshake");
      hold_vld = 1'b0;
    end
  end

  task automatic load(input logic [63:0] wv, input logic [15:0] b, input logic [31:0] neuron);
    cfg_layer_num  = 32'd1;
    cfg_neuron_num = neuron;
    for (int i = 0; i < 4; i++) begin
      weight_valid = 1'b1;
      weight_value = wv[i*16 +: 16];
      tick();
    end
    weight_valid = 1'b0;
    bias_valid   = 1'b1;
    bias_value   = b;
    tick();
    bias_valid   = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, output int acc_cyc, output bit ok);
    int guard;
    bit took;
    in_valid = 1'b1;
    in_data  = d;
    guard    = 0;
    took     = 1'b0;
    ok       = 1'b1;
    acc_cyc  = 0;
    while (!took) begin
      @(negedge clk);
      took    = in_ready_r;
      acc_cyc = cyc;
      tick();
      guard++;
      if (!took && guard > 40) begin
        note_fail("beat_accept");
        ok = 1'b0;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run(input int id, input logic [63:0] x, input logic [15:0] e_relu,
                     input logic [15:0] e_lin, input logic e_sat);
    int   c;
    bit   ok;
    exp_t e;
    send_beat(x[31:0], c, ok);
    if (ok) send_beat(x[63:32], c, ok);
    if (ok) begin
      e.id   = id;
      e.relu = e_relu;
      e.lin  = e_lin;
      e.sat  = e_sat;
      e.cyc  = c + 6;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input string name);
    int guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      tick();
      guard++;
    end
    if (sb.size() != 0) begin
      note_fail(name);
      sb.delete();
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  localparam logic [63:0] W_ONE  = {4{16'h0100}};
  localparam logic [63:0] X_ONE  = {4{16'h0100}};

  initial begin
    int  c;
    bit  ok;
    int  guard;
    rst = 1'b1;
    cfg_layer_num = 32'd0; cfg_neuron_num = 32'd0;
    weight_valid = 1'b0; weight_value = '0;
    bias_valid = 1'b0; bias_value = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

    repeat (3) tick();
    @(negedge clk);
    check("reset_out_valid", out_valid_r, 1'b0);
    check("reset_out_data", out_data_r, 16'h0000);
    check("reset_sat_flag", sat_r, 1'b0);
    check("reset_in_ready", in_ready_r, 1'b0);
    check("reset_weights_loaded", wl_r, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // wrong neuron id: nothing loads, offered beats are not consumed
    load(W_ONE, 16'h0080, 32'd5);
    in_valid = 1'b1;
    in_data  = X_ONE[31:0];
    repeat (5) begin
      @(negedge clk);
      check("t5_in_ready", in_ready_r, 1'b0);
      check("t5_weights_loaded", wl_r, 1'b0);
    end
    tick();
    in_valid = 1'b0;
    tick();

    load(W_ONE, 16'h0080, 32'd0);
    @(negedge clk);
    check("t1_weights_loaded", wl_r, 1'b1);
    tick();
    run(1, X_ONE, 16'h0480, 16'h0480, 1'b0);
    wait_done("t1_done");
    run(11, X_ONE, 16'h0480, 16'h0480, 1'b0);
    wait_done("t1b_done");

    load({4{16'hFF00}}, 16'h0080, 32'd0);
    run(2, X_ONE, 16'h0000, 16'hFC80, 1'b0);
    wait_done("t2_done");

    load({4{16'h7FFF}}, 16'h0080, 32'd0);
    run(3, {4{16'h7FFF}}, 16'h7FFF, 16'h7FFF, 1'b1);
    wait_done("t3_done");

    load({4{16'h8000}}, 16'h0080, 32'd0);
    run(7, {4{16'h7FFF}}, 16'h0000, 16'h8000, 1'b1);
    wait_done("t7_done");

    // distinct weights/lanes: 1*1 + 2*0.5 + 3*(-1) + 4*2 - 0.5 = 6.5
    load({16'h0400, 16'h0300, 16'h0200, 16'h0100}, 16'hFF80, 32'd0);
    run(8, {16'h0200, 16'hFF00, 16'h0080, 16'h0100}, 16'h0680, 16'h0680, 1'b0);
    wait_done("t8_done");

    // sum of -4 LSBs truncates toward -inf: -1 LSB
    load({4{16'h0001}}, 16'h0000, 32'd0);
    run(9, {4{16'hFFFF}}, 16'h0000, 16'hFFFF, 1'b0);
    wait_done("t9_done");

    // stalled output
    load(W_ONE, 16'h0080, 32'd0);
    out_ready = 1'b0;
    run(4, X_ONE, 16'h0480, 16'h0480, 1'b0);
    guard = 0;
    while (!out_valid_r && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!out_valid_r) note_fail("t4_out_valid");
    repeat (10) tick();
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t4_in_ready_after_release", in_ready_r, 1'b1);
    check("t4_out_valid_after_release", out_valid_r, 1'b0);
    tick();
    wait_done("t4_done");

    // reset mid-computation
    send_beat(X_ONE[31:0], c, ok);
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("t6_in_ready", in_ready_r, 1'b0);
    check("t6_out_valid", out_valid_r, 1'b0);
    check("t6_weights_loaded", wl_r, 1'b0);
    check("t6_weights_loaded_lin", wl_l, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) tick();
    load(W_ONE, 16'h0080, 32'd0);
    run(6, X_ONE, 16'h0480, 16'h0480, 1'b0);
    wait_done("t6_done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
